// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: parallel request side and serial/status side of the UART transmitter
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] p_data;
    logic data_valid;
    logic par_en;
    logic par_typ;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic tx_out;
    logic busy;
    logic frame_done;
    modport master (
        output p_data, data_valid, par_en, par_typ, prescale,
        input tx_out, busy, frame_done
    );
    modport slave (
        input p_data, data_valid, par_en, par_typ, prescale,
        output tx_out, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: start/MSB-first data/optional parity/stop framing with per-frame latched prescale
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic clk,
    input logic rst,
    uart_tx_serializer_if.slave bus
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] cyc_q, cyc_d, pre_q;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic par_q, par_en_q, tx_q, busy_q, done_q;
    logic wrap, last_bit;
    assign wrap = cyc_q == pre_q - PW'(1);
    assign last_bit = bit_q == BW'(DATA_WIDTH - 1);
    assign bus.tx_out = tx_q;
    assign bus.busy = busy_q;
    assign bus.frame_done = done_q;
    always_comb begin
        state_d = state_q;
        cyc_d = wrap ? '0 : cyc_q + PW'(1);
        bit_d = bit_q;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                state_d = bus.data_valid ? START : IDLE;
            end
            START: state_d = wrap ? DATA : START;
            DATA: begin
                state_d = wrap && last_bit ? (par_en_q ? PARITY : STOP) : DATA;
                bit_d = wrap && !last_bit ? bit_q + BW'(1) : bit_q;
            end
            PARITY: state_d = wrap ? STOP : PARITY;
            STOP: state_d = wrap ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q <= '0;
            bit_q <= '0;
            data_q <= '0;
            par_q <= 1'b0;
            par_en_q <= 1'b0;
            pre_q <= PW'(1);
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q <= cyc_d;
            bit_q <= bit_d;
            if (state_q == IDLE && bus.data_valid) begin
                data_q <= bus.p_data;
                par_en_q <= bus.par_en;
                par_q <= ^bus.p_data ^ bus.par_typ;
                pre_q <= bus.prescale == '0 ? PW'(1) : bus.prescale;
            end
            tx_q <= state_d == START ? 1'b0 :
                    state_d == DATA ? data_q[BW'(DATA_WIDTH - 1) - bit_d] :
                    state_d == PARITY ? par_q : 1'b1;
            busy_q <= state_d != IDLE;
            done_q <= state_d == STOP && cyc_d == pre_q - PW'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames checked cycle by cycle against a queue of expected frames
module tb_uart_tx_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic [7:0] d;
        logic pe;
        logic pt;
        int p;
    } exp_t;
    exp_t sb[$];
    uart_tx_serializer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();
    uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0d: observed %0h expected %0h", tag, j, obs, exp);
        end
    endtask
    task automatic idle_chk(input string tag);
        chk({tag, "_tx"}, 0, 32'(bus.tx_out), 32'd1);
        chk({tag, "_busy"}, 0, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 0, 32'(bus.frame_done), 32'd0);
    endtask
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                        input bit hold, input bit push);
        exp_t e;
        bus.p_data = d;
        bus.par_en = pe;
        bus.par_typ = pt;
        bus.prescale = ps;
        bus.data_valid = 1'b1;
        e.d = d;
        e.pe = pe;
        e.pt = pt;
        e.p = ps == 0 ? 1 : int'(ps);
        if (push) sb.push_back(e);
        @(negedge clk);
        if (!hold) bus.data_valid = 1'b0;
    endtask
    task automatic check_frame(input int inj_j, input logic [7:0] inj_d, input int inj_len, input int exp_wait);
        exp_t e;
        logic bits[0:10];
        int n = 0;
        int len;
        while (!bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_wait", 0, 32'(n), 32'(exp_wait));
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        len = 10 + int'(e.pe);
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1 + k] = e.d[7 - k];
        bits[9] = e.pe ? (^e.d ^ e.pt) : 1'b1;
        bits[10] = 1'b1;
        for (int j = 0; j < len * e.p; j++) begin
            if (j == inj_j + inj_len) bus.data_valid = 1'b0;
            else if (j >= inj_j && j < inj_j + inj_len) begin
                bus.data_valid = 1'b1;
                bus.p_data = inj_d;
            end
            chk("tx", j, 32'(bus.tx_out), 32'(bits[j / e.p]));
            chk("busy", j, 32'(bus.busy), 32'd1);
            chk("done", j, 32'(bus.frame_done), 32'(j == len * e.p - 1));
            @(negedge clk);
        end
        idle_chk("post");
    endtask
    initial begin
        bus.p_data = '0;
        bus.data_valid = 1'b0;
        bus.par_en = 1'b0;
        bus.par_typ = 1'b0;
        bus.prescale = 6'd8;
        repeat (3) @(negedge clk);
        idle_chk("reset");
        rst = 1'b0;
        @(negedge clk);
        idle_chk("idle");
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        send(8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        send(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
        bus.prescale = 6'd32;
        bus.par_en = 1'b1;
        check_frame(20, 8'hFF, 1, 0);
        repeat (3) begin
            @(negedge clk);
            idle_chk("ignored");
        end
        send(8'hC3, 1'b0, 1'b0, 6'd32, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        send(8'h81, 1'b0, 1'b0, 6'd4, 1'b1, 1'b1);
        sb.push_back('{d: 8'h7E, pe: 1'b0, pt: 1'b0, p: 4});
        check_frame(5, 8'h7E, 1000, 0);
        check_frame(0, 8'h00, 0, 1);
        send(8'h00, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", 0, 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        idle_chk("mid_rst");
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            idle_chk("after_rst");
        end
        send(8'h5A, 1'b1, 1'b0, 6'd4, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        rst = 1'b1;
        bus.data_valid = 1'b1;
        bus.p_data = 8'hFF;
        @(negedge clk);
        idle_chk("rst_dom");
        rst = 1'b0;
        bus.data_valid = 1'b0;
        @(negedge clk);
        idle_chk("rst_dom2");
        send(8'h96, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        send(8'h01, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);
        check_frame(-1, 8'h00, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit path: accepts one parallel byte per handshake and emits a serial frame on tx_out.
- Frame format: start bit (0), DATA_WIDTH data bits MSB first, optional parity bit, one stop bit (1).
- Bit order and parity conventions match the team's UART receive path, so a TX→RX loopback recovers the byte.
- Bit timing comes from a runtime prescale: each bit is held for `prescale` clk cycles, the same oversampling ratio the receiver uses.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_WIDTH, 6, width of the prescale input.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
p_data  input  DATA_WIDTH  parallel byte to transmit.
data_valid  input  1  request to transmit p_data; honoured only when busy=0.
par_en  input  1  1 = insert parity bit after the data bits.
par_typ  input  1  0 = even parity, 1 = odd parity.
prescale  input  PRESCALE_WIDTH  clk cycles per serial bit; 0 is treated as 1.
tx_out  output  1  serial line, idles high.
busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
frame_done  output  1  one-cycle pulse on the last clk cycle of the stop bit.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces tx_out=1, busy=0, frame_done=0, FSM=IDLE, bit counter=0, cycle counter=0.
  - rst dominates data_valid in the same cycle.
  - Reset mid-frame aborts the frame; tx_out is 1 from the next edge, with no partial stop bit.
- Accept:
  - In IDLE with data_valid=1 at edge N, the block latches p_data, par_en and par_typ.
  - prescale is latched at the same edge (0 is stored as 1).
  - The parity bit is computed at the same edge: even = XOR of the data bits; odd = XNOR of the data bits.
- Output timing: all outputs are registered.
  - tx_out=0 and busy=1 from edge N+1 (one-cycle latency).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state holds tx_out constant for exactly P latched-prescale cycles. A cycle counter runs 0..P-1 and resets to 0 on every state or bit change.
  - START: tx_out=0 → DATA.
  - DATA: tx_out=data[DATA_WIDTH-1-k] for k=0..DATA_WIDTH-1 (MSB first). The bit counter advances on each cycle-counter wrap; after the last bit → PARITY if par_en else → STOP.
  - PARITY: tx_out=parity bit → STOP.
  - STOP: tx_out=1. On the last cycle frame_done=1, and the next state is IDLE.
  - IDLE: tx_out=1, busy=0.
- Frame length in clk cycles (tx_out driven by the frame): (2 + DATA_WIDTH + par_en) × P.
- busy falls on the edge entering IDLE. frame_done is never asserted outside that final STOP cycle.
- data_valid while busy=1 is ignored: no latch, no error, no effect on the current frame.
- Back-to-back: if data_valid is held high, the next byte is accepted in the IDLE cycle. This gives exactly one extra idle-high cycle between stop bit and next start bit.
- Input changes during a frame (p_data, par_en, par_typ, prescale) have no effect until the next accept.
- Counters: cycle counter PRESCALE_WIDTH bits wide; bit counter wide enough for DATA_WIDTH-1; neither wraps beyond its terminal value.

Test Plan:
- prescale=8, par_en=0, one pulse of data_valid with p_data=0xA5 → tx_out sequence per 8-cycle bit: 0,1,0,1,0,0,1,0,1,1. busy high 80 cycles; frame_done pulses in cycle 80; tx_out=1 afterwards.
- prescale=16, par_en=1, par_typ=0, p_data=0xA5 (four ones) → parity bit 0. Frame is 11 bits = 176 cycles; same byte with par_typ=1 → parity bit 1.
- prescale=8, data_valid pulsed with 0x3C, then data_valid again mid-frame with 0xFF → only 0x3C is transmitted, and busy does not extend.
- data_valid held high, p_data=0x81 then 0x7E, prescale=4, no parity → two frames of 40 cycles, separated by exactly one idle-high cycle.
- rst=1 during DATA bit 3 of a 0x00 frame → tx_out=1, busy=0 at the next edge. A new data_valid after rst drops starts a clean frame.
- prescale changed from 8 to 32 during a frame → current frame keeps 8-cycle bits; next frame uses 32. prescale=0 → 1-cycle bits.
